// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu_seq multi-cycle ALU: op codes, flag bit
// positions inside the {z,c,n} triplet, and FSM state encodings.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_SHL = 3'd4,
        OP_SHR = 3'd5,
        OP_MUL = 3'd6,
        OP_DIV = 3'd7
    } op_e;

    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative datapath for alu_seq: shift-add multiply and, when ALU_SEQ_DIV_EN
// is defined, restoring shift-subtract divide. One step per cycle, W steps.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi_next,
    output logic [DATA_WIDTH-1:0] lo_next
);

    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(W - 1);

    // hi: partial product / remainder; lo: multiplier / quotient; opnd: A or divisor
    logic [W-1:0]         hi_q, hi_d;
    logic [W-1:0]         lo_q, lo_d;
    logic [W-1:0]         opnd_q, opnd_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic [W:0]           mul_sum;

`ifdef ALU_SEQ_DIV_EN
    logic                 mode_q, mode_d;
    logic [W:0]           rem_sh;
    logic [W:0]           rem_diff;
`endif

    // done flags the cycle whose step is the last one; its result is hi/lo_next
    assign done = busy_q && (cnt_q == CNT_LAST);

    always_comb begin
        mul_sum = {1'b0, hi_q} + ({1'b0, opnd_q} & {(W + 1){lo_q[0]}});
        hi_next = mul_sum[W:1];
        lo_next = {mul_sum[0], lo_q[W-1:1]};
`ifdef ALU_SEQ_DIV_EN
        rem_sh   = {hi_q, lo_q[W-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};
        if (mode_q) begin
            if (!rem_diff[W]) begin
                hi_next = rem_diff[W-1:0];
                lo_next = {lo_q[W-2:0], 1'b1};
            end else begin
                hi_next = rem_sh[W-1:0];
                lo_next = {lo_q[W-2:0], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
`ifdef ALU_SEQ_DIV_EN
        mode_d = mode_q;
`endif
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            hi_d   = '0;
            lo_d   = mode ? a : b;
            opnd_d = mode ? b : a;
`ifdef ALU_SEQ_DIV_EN
            mode_d = mode;
`endif
        end else if (busy_q) begin
            hi_d   = hi_next;
            lo_d   = lo_next;
            cnt_d  = cnt_q + CNT_WIDTH'(1);
            busy_d = !done;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            mode_q <= 1'b0;
`endif
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
`ifdef ALU_SEQ_DIV_EN
            mode_q <= mode_d;
`endif
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready on operands and result, {z,c,n} flags.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise DIV returns c=1 in one cycle.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic [2:0]            iOp,
    input  logic [DATA_WIDTH-1:0] iA,
    input  logic [DATA_WIDTH-1:0] iB,
    output logic                  oValid,
    input  logic                  iReady,
    output logic [DATA_WIDTH-1:0] oResultLo,
    output logic [DATA_WIDTH-1:0] oResultHi,
    output logic [2:0]            oFlags
);

    localparam int W = DATA_WIDTH;

    state_e       state_q, state_d;
    logic         ready_q, ready_d;
    logic         valid_q, valid_d;
    logic [W-1:0] lo_q, lo_d;
    logic [W-1:0] hi_q, hi_d;
    logic [2:0]   flags_q, flags_d;
    logic         div_q, div_d;
    logic         div0_q, div0_d;

    logic         accept;
    logic         is_iter_op;
    logic         iter_start;
    logic         iter_mode;
    logic         iter_done;
    logic [W-1:0] iter_hi;
    logic [W-1:0] iter_lo;
    logic [W:0]   alu_wide;
    logic [W-1:0] alu_lo;
    logic         alu_c;

    assign accept = iValid && ready_q;
`ifdef ALU_SEQ_DIV_EN
    assign is_iter_op = (iOp == OP_MUL) || (iOp == OP_DIV);
`else
    assign is_iter_op = (iOp == OP_MUL);
`endif
    assign iter_start = accept && is_iter_op;
    assign iter_mode  = (iOp == OP_DIV);

    alu_seq_iter #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_iter (
        .Clock   (Clock),
        .Reset   (Reset),
        .start   (iter_start),
        .mode    (iter_mode),
        .a       (iA),
        .b       (iB),
        .done    (iter_done),
        .hi_next (iter_hi),
        .lo_next (iter_lo)
    );

    always_comb begin
        alu_wide = '0;
        alu_c    = 1'b0;
        case (iOp)
            OP_ADD: begin
                alu_wide = {1'b0, iA} + {1'b0, iB};
                alu_c    = alu_wide[W];
            end
            OP_SUB: begin
                alu_wide = {1'b0, iA} - {1'b0, iB};
                alu_c    = alu_wide[W];
            end
            OP_AND: alu_wide = {1'b0, iA & iB};
            OP_OR:  alu_wide = {1'b0, iA | iB};
            OP_SHL: begin
                alu_wide = {1'b0, iA[W-2:0], 1'b0};
                alu_c    = iA[W-1];
            end
            OP_SHR: begin
                alu_wide = {2'b00, iA[W-1:1]};
                alu_c    = iA[0];
            end
            // only DIV without the divider lands here: zero result, c marks unsupported
            default: alu_c = 1'b1;
        endcase
        alu_lo = alu_wide[W-1:0];
    end

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        valid_d = valid_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        flags_d = flags_q;
        div_d   = div_q;
        div0_d  = div0_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ready_d = 1'b0;
                    div_d   = (iOp == OP_DIV);
                    div0_d  = (iB == '0);
                    if (is_iter_op) begin
                        state_d = ST_CALC;
                    end else begin
                        state_d         = ST_DONE;
                        valid_d         = 1'b1;
                        lo_d            = alu_lo;
                        hi_d            = '0;
                        flags_d[FLAG_Z] = (alu_lo == '0);
                        flags_d[FLAG_C] = alu_c;
                        flags_d[FLAG_N] = alu_lo[W-1];
                    end
                end
            end
            ST_CALC: begin
                if (iter_done) begin
                    state_d         = ST_DONE;
                    valid_d         = 1'b1;
                    lo_d            = iter_lo;
                    hi_d            = iter_hi;
                    flags_d[FLAG_Z] = ({iter_hi, iter_lo} == '0);
                    flags_d[FLAG_C] = div_q ? div0_q : (iter_hi != '0);
                    flags_d[FLAG_N] = iter_lo[W-1];
                end
            end
            ST_DONE: begin
                if (iReady) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            flags_q <= '0;
            div_q   <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            flags_q <= flags_d;
            div_q   <= div_d;
            div0_q  <= div0_d;
        end
    end

    assign oReady    = ready_q;
    assign oValid    = valid_q;
    assign oResultLo = lo_q;
    assign oResultHi = hi_q;
    assign oFlags    = flags_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, multi-cycle successor to the accumulator-machine ALU. It adds an iterative multiply and a restoring divide to the single-cycle add/sub/logic/shift ops. It uses a valid/ready handshake on both the operand side and the result side, and produces the {z,c,n} flag triplet alongside the result. It sits between the decode stage and the accumulator write-back, and the pipeline stalls on the oReady/oValid handshake.

Parameters:
- DATA_WIDTH, 8: operand width W. Legal for W >= 2.
- CNT_WIDTH, $clog2(DATA_WIDTH+1): width of the iteration counter. Derived; not overridden.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- iValid  in  1  operands and op are presented.
- oReady  out  1  block can accept an op; high only in IDLE.
- iOp  in  3  operation code from the package.
- iA  in  W  operand A (accumulator side).
- iB  in  W  operand B (memory or immediate side).
- oValid  out  1  result is held and valid.
- iReady  in  1  consumer accepts the result.
- oResultLo  out  W  result, low word (sum, product low, quotient).
- oResultHi  out  W  product high word or remainder; 0 for single-cycle ops.
- oFlags  out  3  {z,c,n}.

Behaviour:
- Interface: Clock; reset Reset, synchronous, active-high.
- Reset values: oValid=0, oReady=1 (IDLE), oResultLo=0, oResultHi=0, oFlags=0, counter=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - oReady=1.
  - Accept when iValid&oReady: capture iA, iB, iOp.
  - Ops ADD, SUB, AND, OR, SHL, SHR: compute and register the result in the acceptance cycle, then go to DONE. oValid is high the next cycle (latency 1).
  - Ops MUL, DIV: load the datapath, counter=0, go to CALC.
- CALC:
  - One shift-add (MUL) or shift-subtract (DIV) step per cycle.
  - After W steps, register the result and go to DONE. oValid first high W+1 cycles after acceptance.
  - iValid is ignored.
- DONE:
  - oValid=1. Outputs are held stable until iValid's counterpart iReady=1.
  - On the oValid&iReady cycle: go to IDLE, oValid=0 next cycle. The result registers keep their value.
  - No new op is accepted in the same cycle; max throughput is 1 op per 2 cycles.
- Arithmetic (W-bit, unsigned):
  - ADD: c = carry out.
  - SUB: lo = A-B; c = borrow (A<B).
  - AND/OR: c = 0.
  - SHL: c = A[W-1].
  - SHR: logical shift; c = A[0].
  - MUL: {hi,lo} = A*B (2W bits); c = (hi != 0).
  - DIV: lo = A/B, hi = A%B; c = 0.
- Flags:
  - z = (lo==0) for single-cycle ops; z = ({hi,lo}==0) for MUL/DIV.
  - n = lo[W-1].
- Divide by zero: lo = all ones, hi = A, c = 1, z = 0. Latency is unchanged at W+1.
- Reset mid-CALC or mid-DONE: next cycle is IDLE with all outputs at reset values. The pending op is discarded without a result.
- iValid and iReady both high in DONE: only the result transfer occurs. iValid is ignored until the next IDLE cycle.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined: DIV is implemented as above.
- Undefined: divide logic is not built. DIV completes with latency 1 and gives lo=0, hi=0, flags={1,1,0}. c=1 signals an unsupported op. MUL is unaffected.

Decomposition:
- Package alu_seq_pkg:
  - Op codes: ADD=0, SUB=1, AND=2, OR=3, SHL=4, SHR=5, MUL=6, DIV=7.
  - Flag index constants: FLAG_Z=2, FLAG_C=1, FLAG_N=0.
  - FSM state encodings: IDLE=0, CALC=1, DONE=2.
- One sub-module, alu_seq_iter:
  - Iterative shift-add/shift-subtract datapath holding the partial product or remainder registers and the counter.
  - Signals: start, mode, done-after-W.
  - The divide half sits under ALU_SEQ_DIV_EN.

Test Plan (W=8):
1. ADD A=200, B=100, iReady=1 -> oValid 1 cycle after accept; lo=0x2C, hi=0, flags={0,1,0}. SUB A=5, B=7 -> lo=0xFE, flags={0,1,1}.
2. MUL A=15, B=17 -> oValid 9 cycles after accept; hi=0x00, lo=0xFF, flags={0,0,1}. MUL A=200, B=200 -> hi=0x9C, lo=0x40, flags={0,1,0}.
3. DIV A=100, B=7 -> lo=14, hi=2, flags={0,0,0}. DIV A=0x55, B=0 -> lo=0xFF, hi=0x55, flags={0,1,1}. With ALU_SEQ_DIV_EN undefined -> lo=0, hi=0, flags={1,1,0}, latency 1.
4. Backpressure: ADD 1+1 with iReady=0 for 5 cycles -> oValid, lo=2 and flags stable throughout; oReady=0; a second iValid pulse is ignored. Release iReady -> IDLE next cycle, then the second op is accepted.
5. Reset asserted on the 4th CALC cycle of MUL 255*255 -> next cycle oValid=0, oReady=1, all outputs 0. A fresh ADD 3+4 then yields lo=7.
6. SHL A=0x81 -> lo=0x02, flags={0,1,0}. SHR A=0x01 -> lo=0x00, flags={1,1,0}.
